rf_write_arbiter: RTL and testbench

- Shares the register file's single write port (we/a3/wd) between two requesters.
- Requester A is the core writeback path: highest priority, no backpressure.
- Requester B is a long-latency unit (load/mul/div). It uses a valid/ready handshake and is buffered in a DEPTH-entry FIFO.
- Also provides starvation protection (stall request to core) and pending-write hazard flags for the decode read addresses.

---
 rtl/rf_write_arbiter.sv | 121 ++++++++++++
 tb/tb_rf_write_arbiter.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/rf_write_arbiter.sv
// Register-file write-port arbiter: core writeback vs. a buffered
// long-latency requester, with starvation guard and pending-write hazard flags.
module rf_write_arbiter #(
  parameter int DEPTH    = 4,
  parameter int MAX_WAIT = 8
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     a_we,
  input  logic [4:0]               a_rd,
  input  logic [31:0]              a_wd,
  input  logic                     b_valid,
  output logic                     b_ready,
  input  logic [4:0]               b_rd,
  input  logic [31:0]              b_wd,
  output logic                     rf_we,
  output logic [4:0]               rf_a3,
  output logic [31:0]              rf_wd,
  output logic                     core_stall,
  input  logic [4:0]               chk_a1,
  input  logic [4:0]               chk_a2,
  output logic                     pend_hit1,
  output logic                     pend_hit2,
  output logic [$clog2(DEPTH):0]   fifo_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int WW = $clog2(MAX_WAIT + 1);

  logic [4:0]       q_rd [DEPTH];
  logic [31:0]      q_wd [DEPTH];
  logic [DEPTH-1:0] vld;
  logic [AW-1:0]    wptr;
  logic [AW-1:0]    rptr;
  logic [CW-1:0]    count;
  logic [WW-1:0]    wait_cnt;

  logic empty;
  logic full;
  logic force_b;
  logic a_eff;
  logic push;
  logic pop;
  logic hit1;
  logic hit2;

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign force_b = !empty && (wait_cnt == WW'(MAX_WAIT));
  assign a_eff   = a_we && (a_rd != 5'd0);
  assign pop     = !empty && (force_b || !a_eff);
  assign push    = b_valid && !full && (b_rd != 5'd0);

  always_comb begin
    rf_we      = 1'b0;
    rf_a3      = 5'd0;
    rf_wd      = 32'd0;
    core_stall = 1'b0;
    if (reset_n) begin
      core_stall = force_b;
      if (pop) begin
        rf_we = 1'b1;
        rf_a3 = q_rd[rptr];
        rf_wd = q_wd[rptr];
      end else if (a_eff) begin
        rf_we = 1'b1;
        rf_a3 = a_rd;
        rf_wd = a_wd;
      end
    end
  end

  // Hazard lookup sees the queue as it stands before this edge.
  always_comb begin
    hit1 = 1'b0;
    hit2 = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (vld[i] && (q_rd[i] == chk_a1)) hit1 = 1'b1;
      if (vld[i] && (q_rd[i] == chk_a2)) hit2 = 1'b1;
    end
  end

  assign pend_hit1  = reset_n && (chk_a1 != 5'd0) && hit1;
  assign pend_hit2  = reset_n && (chk_a2 != 5'd0) && hit2;
  assign b_ready    = reset_n && !full;
  assign fifo_count = reset_n ? count : '0;

  always_ff @(posedge clk) begin
    if (push) begin
      q_rd[wptr] <= b_rd;
      q_wd[wptr] <= b_wd;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wptr     <= '0;
      rptr     <= '0;
      count    <= '0;
      wait_cnt <= '0;
      vld      <= '0;
    end else begin
      if (push) begin
        vld[wptr] <= 1'b1;
        wptr      <= wptr + 1'b1;
      end
      if (pop) begin
        vld[rptr] <= 1'b0;
        rptr      <= rptr + 1'b1;
      end
      count <= count + CW'(push) - CW'(pop);
      if (pop || empty) begin
        wait_cnt <= '0;
      end else if (wait_cnt != WW'(MAX_WAIT)) begin
        wait_cnt <= wait_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Directed bench for rf_write_arbiter; expected regfile writes are
// queued by the driver and matched by an independent write monitor.
module tb_rf_write_arbiter;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        a_we;
  logic [4:0]  a_rd;
  logic [31:0] a_wd;
  logic        b_valid;
  logic        b_ready;
  logic [4:0]  b_rd;
  logic [31:0] b_wd;
  logic        rf_we;
  logic [4:0]  rf_a3;
  logic [31:0] rf_wd;
  logic        core_stall;
  logic [4:0]  chk_a1;
  logic [4:0]  chk_a2;
  logic        pend_hit1;
  logic        pend_hit2;
  logic [2:0]  fifo_count;

  int n_cmp = 0;
  int n_err = 0;
  logic [36:0] exp_q [$];

  rf_write_arbiter #(.DEPTH(4), .MAX_WAIT(8)) dut (
    .clk(clk), .reset_n(reset_n),
    .a_we(a_we), .a_rd(a_rd), .a_wd(a_wd),
    .b_valid(b_valid), .b_ready(b_ready),
    .b_rd(b_rd), .b_wd(b_wd),
    .rf_we(rf_we), .rf_a3(rf_a3), .rf_wd(rf_wd),
    .core_stall(core_stall),
    .chk_a1(chk_a1), .chk_a2(chk_a2),
    .pend_hit1(pend_hit1), .pend_hit2(pend_hit2),
    .fifo_count(fifo_count)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    logic [36:0] e;
    if (rf_we) begin
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL unexpected_write got a3=%0d wd=%h, required none",
                 rf_a3, rf_wd);
      end else begin
        e = exp_q.pop_front();
        if ({rf_a3, rf_wd} !== e) begin
          n_err++;
          $display("FAIL write got a3=%0d wd=%h, required a3=%0d wd=%h",
                   rf_a3, rf_wd, e[36:32], e[31:0]);
        end
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s got %h, required %h", nm, act, exp);
    end
  endtask

  task automatic expw(input logic [4:0] rd, input logic [31:0] wd);
    exp_q.push_back({rd, wd});
  endtask

  task automatic set_in(input logic awe, input logic [4:0] ard,
                        input logic [31:0] awd, input logic bv,
                        input logic [4:0] brd, input logic [31:0] bwd);
    a_we = awe; a_rd = ard; a_wd = awd;
    b_valid = bv; b_rd = brd; b_wd = bwd;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic at_neg();
    @(negedge clk);
  endtask

  initial begin
    int idx;
    logic exp_stall;
    logic [2:0] exp_cnt;
    reset_n = 1'b0;
    chk_a1 = 5'd0;
    chk_a2 = 5'd0;
    set_in(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    tick();
    tick();
    at_neg();
    chk("rst_rf_we", rf_we, 0);
    chk("rst_b_ready", b_ready, 0);
    chk("rst_count", fifo_count, 0);
    chk("rst_stall", core_stall, 0);
    tick();
    reset_n = 1'b1;

    // 1: core write, same-cycle
    set_in(1'b1, 5'd1, 32'h12345678, 1'b0, 5'd0, 32'd0);
    expw(5'd1, 32'h12345678);
    at_neg();
    chk("t1_stall", core_stall, 0);
    chk("t1_count", fifo_count, 0);
    tick();

    // 2: single B entry, written the cycle after acceptance
    set_in(1'b0, 5'd0, 32'd0, 1'b1, 5'd2, 32'h9ABCDEF0);
    at_neg();
    chk("t2_ready", b_ready, 1);
    chk("t2_nobypass", rf_we, 0);
    tick();
    set_in(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    expw(5'd2, 32'h9ABCDEF0);
    at_neg();
    chk("t2_count1", fifo_count, 1);
    tick();
    at_neg();
    chk("t2_count0", fifo_count, 0);
    chk("t2_idle", rf_we, 0);
    tick();

    // 3: fill with A busy; starvation guard forces one B every 9 cycles
    for (int k = 0; k < 38; k++) begin
      set_in(1'b1, 5'd7, 32'hA0000000 + k, k < 5,
             5'(3 + k), 32'hB0000003 + k);
      if (k > 0 && (k % 9) == 0) begin
        idx = k / 9 - 1;
        expw(5'(3 + idx), 32'hB0000003 + idx);
        exp_stall = 1'b1;
      end else begin
        expw(5'd7, 32'hA0000000 + k);
        exp_stall = 1'b0;
      end
      exp_cnt = (k <= 4)  ? 3'(k) :
                (k <= 9)  ? 3'd4 :
                (k <= 18) ? 3'd3 :
                (k <= 27) ? 3'd2 :
                (k <= 36) ? 3'd1 : 3'd0;
      at_neg();
      chk($sformatf("t3_stall_k%0d", k), core_stall, exp_stall);
      chk($sformatf("t3_count_k%0d", k), fifo_count, exp_cnt);
      if (k == 4) chk("t3_full_ready", b_ready, 0);
      tick();
    end

    // 4: x0 from both sides is dropped
    set_in(1'b1, 5'd0, 32'h55555555, 1'b1, 5'd0, 32'hFFFFFFFF);
    at_neg();
    chk("t4_ready", b_ready, 1);
    chk("t4_we", rf_we, 0);
    tick();
    set_in(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    at_neg();
    chk("t4_count", fifo_count, 0);
    chk("t4_we_next", rf_we, 0);
    tick();

    // 5: pending-write hazard flags
    set_in(1'b1, 5'd5, 32'h50000000, 1'b1, 5'd9, 32'h99999999);
    expw(5'd5, 32'h50000000);
    tick();
    set_in(1'b1, 5'd5, 32'h50000001, 1'b0, 5'd0, 32'd0);
    chk_a1 = 5'd9;
    chk_a2 = 5'd0;
    expw(5'd5, 32'h50000001);
    at_neg();
    chk("t5_hit1", pend_hit1, 1);
    chk("t5_hit2_x0", pend_hit2, 0);
    tick();
    set_in(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    chk_a2 = 5'd10;
    expw(5'd9, 32'h99999999);
    at_neg();
    chk("t5_hit1_popping", pend_hit1, 1);
    chk("t5_hit2_miss", pend_hit2, 0);
    tick();
    at_neg();
    chk("t5_hit1_after", pend_hit1, 0);
    chk("t5_count", fifo_count, 0);
    tick();

    // 6: reset mid-operation drops queued entries
    chk_a1 = 5'd12;
    chk_a2 = 5'd0;
    for (int k = 0; k < 3; k++) begin
      set_in(1'b1, 5'd11, 32'hC0000000 + k, 1'b1,
             5'(12 + k), 32'hD0000000 + k);
      expw(5'd11, 32'hC0000000 + k);
      tick();
    end
    set_in(1'b1, 5'd11, 32'hC0000003, 1'b0, 5'd0, 32'd0);
    at_neg();
    chk("t6_count3", fifo_count, 3);
    chk("t6_hit_before", pend_hit1, 1);
    expw(5'd11, 32'hC0000003);
    tick();
    reset_n = 1'b0;
    at_neg();
    chk("t6_rst_count", fifo_count, 0);
    chk("t6_rst_we", rf_we, 0);
    chk("t6_rst_ready", b_ready, 0);
    chk("t6_rst_hit", pend_hit1, 0);
    tick();
    reset_n = 1'b1;
    set_in(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    at_neg();
    chk("t6_ready", b_ready, 1);
    chk("t6_count0", fifo_count, 0);
    chk("t6_hit_after", pend_hit1, 0);
    for (int k = 0; k < 4; k++) begin
      tick();
      at_neg();
      chk($sformatf("t6_no_stale_k%0d", k), rf_we, 0);
    end
    tick();

    at_neg();
    #1;
    chk("leftover_expected", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
